// File: rtl/bufg_ibuf_if.sv
// Control and status bundle for the bufg_ibuf clock buffer/gate.
// The bench drives through master; the buffer implements slave.
interface bufg_ibuf_if #(
   parameter int CNT_W = 6
);
   logic             ce;
   logic             clr;
   logic             en_active;
   logic [CNT_W-1:0] edge_cnt;
   logic             cnt_sat;
   logic             clk_seen;

   modport master (
      output ce,
      output clr,
      input  en_active,
      input  edge_cnt,
      input  cnt_sat,
      input  clk_seen
   );

   modport slave (
      input  ce,
      input  clr,
      output en_active,
      output edge_cnt,
      output cnt_sat,
      output clk_seen
   );
endinterface

// File: rtl/bufg_ibuf.sv
// Pad buffer plus glitch-free gated global clock with a saturating edge counter.
// The enable changes only on falling spi_clk, so clk_global pulses are never cut short.
module bufg_ibuf #(
   parameter int CNT_W       = 6,
   parameter int CNT_MAX     = 33,
   parameter int SYNC_STAGES = 2
) (
   input  logic          spi_clk,
   input  logic          rst_n,
   output logic          clk_ibuf,
   output logic          clk_global,
   bufg_ibuf_if.slave    bus
);
   localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_MAX[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   en_q_r;
   logic [CNT_W-1:0]       edge_cnt_r;
   logic                   clk_seen_r;

   assign clk_ibuf   = spi_clk;
   assign clk_global = clk_ibuf & en_q_r;

   // Falling-edge synchronizer for ce, followed by the gate-enable flop.
   always_ff @(negedge spi_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         en_q_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], bus.ce};
         en_q_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Counts enabled rising edges, saturating at CNT_MAX; clr wins over increment.
   always_ff @(posedge spi_clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_r <= {CNT_W{1'b0}};
         clk_seen_r <= 1'b0;
      end else begin
         if (bus.clr) begin
            edge_cnt_r <= {CNT_W{1'b0}};
         end else if (en_q_r && (edge_cnt_r != CNT_MAX_V)) begin
            edge_cnt_r <= edge_cnt_r + CNT_ONE;
         end else begin
            edge_cnt_r <= edge_cnt_r;
         end
         if (en_q_r) begin
            clk_seen_r <= 1'b1;
         end else begin
            clk_seen_r <= clk_seen_r;
         end
      end
   end

   assign bus.en_active = en_q_r;
   assign bus.edge_cnt  = edge_cnt_r;
   assign bus.cnt_sat   = (edge_cnt_r == CNT_MAX_V);
   assign bus.clk_seen  = clk_seen_r;
endmodule

// File: tb/tb_bufg_ibuf.sv
// Directed bench for bufg_ibuf: per-cycle vector table plus hand-written
// sequences for glitch rejection, saturation and reset mid-pulse.
module tb_bufg_ibuf;
   logic spi_clk;
   logic rst_n;
   logic clk_ibuf;
   logic clk_global;

   bufg_ibuf_if #(.CNT_W(6)) bus ();

   bufg_ibuf #(.CNT_W(6), .CNT_MAX(33), .SYNC_STAGES(2)) dut (
      .spi_clk    (spi_clk),
      .rst_n      (rst_n),
      .clk_ibuf   (clk_ibuf),
      .clk_global (clk_global),
      .bus        (bus.slave)
   );

   typedef struct {
      logic       ce;
      logic       clr;
      logic       en;
      logic [5:0] cnt;
      logic       sat;
      logic       seen;
   } vec_t;

   vec_t tbl [19];
   int   checks = 0;
   int   errors = 0;
   logic prev_en;

   initial spi_clk = 1'b0;
   always #5 spi_clk = ~spi_clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Called at rising edge + 1; returns at the next rising edge + 1.
   task automatic step(input logic ce_i, input logic clr_i, input logic en_e,
                       input logic [5:0] cnt_e, input logic sat_e, input logic seen_e,
                       input string nm);
      bus.ce  = ce_i;
      bus.clr = clr_i;
      #3;
      chk({nm, ".pulse_width"}, {31'd0, clk_global}, {31'd0, prev_en});
      @(negedge spi_clk); #1;
      chk({nm, ".en_active"}, {31'd0, bus.en_active}, {31'd0, en_e});
      chk({nm, ".glob_low"}, {31'd0, clk_global}, 32'd0);
      @(posedge spi_clk); #1;
      chk({nm, ".glob_high"}, {31'd0, clk_global}, {31'd0, en_e});
      chk({nm, ".edge_cnt"}, {26'd0, bus.edge_cnt}, {26'd0, cnt_e});
      chk({nm, ".cnt_sat"}, {31'd0, bus.cnt_sat}, {31'd0, sat_e});
      chk({nm, ".clk_seen"}, {31'd0, bus.clk_seen}, {31'd0, seen_e});
      prev_en = en_e;
   endtask

   initial begin
      logic [5:0] exp_cnt;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 1'b1};
      for (int i = 3; i <= 11; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 6'(i - 1), 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 6'd4, 1'b0, 1'b1};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 6'd4, 1'b0, 1'b1};

      rst_n   = 1'b0;
      bus.ce  = 1'b0;
      bus.clr = 1'b0;
      prev_en = 1'b0;

      // Held in reset: clk_ibuf follows the pad, everything else stays cleared.
      for (int i = 0; i < 3; i++) begin
         @(posedge spi_clk); #1;
         chk("rst.ibuf_hi", {31'd0, clk_ibuf}, 32'd1);
         chk("rst.glob", {31'd0, clk_global}, 32'd0);
         chk("rst.en", {31'd0, bus.en_active}, 32'd0);
         chk("rst.cnt", {26'd0, bus.edge_cnt}, 32'd0);
         chk("rst.sat", {31'd0, bus.cnt_sat}, 32'd0);
         chk("rst.seen", {31'd0, bus.clk_seen}, 32'd0);
         @(negedge spi_clk); #1;
         chk("rst.ibuf_lo", {31'd0, clk_ibuf}, 32'd0);
         chk("rst.glob_lo", {31'd0, clk_global}, 32'd0);
      end

      @(posedge spi_clk); #1;
      rst_n = 1'b1;

      // Enable latency, count, clr mid-run, and ce drop with full-width last pulse.
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].ce, tbl[i].clr, tbl[i].en, tbl[i].cnt, tbl[i].sat, tbl[i].seen,
              $sformatf("vec%0d", i));
      end

      // A ce glitch that no falling edge samples must never enable the gate.
      bus.ce = 1'b1;
      #1;
      bus.ce = 1'b0;
      @(posedge spi_clk); #1;
      chk("glitch.en", {31'd0, bus.en_active}, 32'd0);
      chk("glitch.cnt", {26'd0, bus.edge_cnt}, 32'd4);
      step(1'b0, 1'b0, 1'b0, 6'd4, 1'b0, 1'b1, "glitch_a");
      step(1'b0, 1'b0, 1'b0, 6'd4, 1'b0, 1'b1, "glitch_b");

      // Re-enable and run 40 counted edges: the counter must stick at 33.
      exp_cnt = 6'd4;
      step(1'b1, 1'b0, 1'b0, exp_cnt, 1'b0, 1'b1, "sat_lat0");
      step(1'b1, 1'b0, 1'b0, exp_cnt, 1'b0, 1'b1, "sat_lat1");
      for (int i = 0; i < 40; i++) begin
         exp_cnt = (exp_cnt < 6'd33) ? exp_cnt + 6'd1 : 6'd33;
         step(1'b1, 1'b0, 1'b1, exp_cnt, (exp_cnt == 6'd33), 1'b1, $sformatf("sat%0d", i));
      end

      // Reset while clk_global is high truncates the pulse at once.
      chk("midrst.pre_glob", {31'd0, clk_global}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst.glob", {31'd0, clk_global}, 32'd0);
      chk("midrst.cnt", {26'd0, bus.edge_cnt}, 32'd0);
      chk("midrst.sat", {31'd0, bus.cnt_sat}, 32'd0);
      chk("midrst.seen", {31'd0, bus.clk_seen}, 32'd0);
      chk("midrst.en", {31'd0, bus.en_active}, 32'd0);
      chk("midrst.ibuf", {31'd0, clk_ibuf}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge spi_clk); #1;
         chk("midrst.ibuf_lo", {31'd0, clk_ibuf}, 32'd0);
         @(posedge spi_clk); #1;
         chk("midrst.ibuf_hi", {31'd0, clk_ibuf}, 32'd1);
         chk("midrst.glob_hold", {31'd0, clk_global}, 32'd0);
      end
      rst_n   = 1'b1;
      prev_en = 1'b0;
      step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, "reen0");
      step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, "reen1");
      step(1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 1'b1, "reen2");
      step(1'b1, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1, "reen3");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
